// File: rtl/lite_pkg.sv
// Shared types for the LEGv8-lite core.
// Opcodes, instruction fields, fetch FSM and IF/ID bundle.
package lite_pkg;

  typedef enum logic [3:0] {
    OP_LD   = 4'd5,
    OP_ST   = 4'd6,
    OP_CBZ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_ANDI = 4'd9
  } op_e;

  localparam logic [2:0] XZR = 3'd7;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] imm6;
    logic [2:0] rs;
    logic [2:0] rd;
  } instr_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fstate_e;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
  } if_id_t;

  // CBZ on XZR always branches
  function automatic logic is_uncond(
    input logic [15:0] w
  );
    instr_t f;
    f = instr_t'(w);
    return (f.op == OP_CBZ) && (f.rs == XZR);
  endfunction

  function automatic logic [5:0] imm6_of(
    input logic [15:0] w
  );
    instr_t f;
    f = instr_t'(w);
    return f.imm6;
  endfunction

endpackage

// File: rtl/fetch_stage_branch_target.sv
// PC-relative branch target adder.
// Word offset imm6 is sign-extended and scaled to bytes.
module branch_target (
  input  logic [15:0] pc_i,
  input  logic [5:0]  imm6_i,
  output logic [15:0] target_o
);

  logic [15:0] off;

  // sext(imm6) << 1, modulo-16 add
  always_comb begin
    off      = {{9{imm6_i[5]}}, imm6_i, 1'b0};
    target_o = pc_i + off;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, IF/ID register, branch folding.
// Redirect beats stall beats fold beats sequential fetch.
module fetch_stage
  import lite_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          FOLD_UNCOND = 1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [15:0]      iaddr,
  input  logic [15:0]      idata,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [15:0]      redir_target,
  output logic             id_valid,
  output logic [15:0]      id_instr,
  output logic [15:0]      id_pc,
  output logic [CNT_W-1:0] fetch_count
);

  fstate_e          state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  if_id_t           ifid_q, ifid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] tgt;
  logic        fold;
  logic        run;
  logic        sel_redir;
  logic        sel_stall;
  logic        sel_fold;
  logic        sel_seq;
  logic        unused_lsb;

  assign unused_lsb = redir_target[0];

  branch_target u_bt (
    .pc_i     (pc_q),
    .imm6_i   (imm6_of(idata)),
    .target_o (tgt)
  );

  assign fold = (FOLD_UNCOND != 0)
             && is_uncond(idata);
  assign run  = (state_q == RUN);

  // one-hot select of the next-PC source
  always_comb begin
    sel_redir = run && redir_valid;
    sel_stall = run && !redir_valid && stall;
    sel_fold  = run && !redir_valid
             && !stall && fold;
    sel_seq   = run && !redir_valid
             && !stall && !fold;
  end

  // next state, next PC, IF/ID and counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    if (state_q == BOOT) begin
      state_d = RUN;
    end
    unique case (1'b1)
      sel_redir: begin
        pc_d         = {redir_target[15:1], 1'b0};
        ifid_d.valid = 1'b0;
      end
      sel_stall: begin
        pc_d = pc_q;
      end
      sel_fold: begin
        pc_d         = tgt;
        ifid_d.valid = 1'b0;
      end
      sel_seq: begin
        pc_d         = pc_q + 16'd2;
        ifid_d.valid = 1'b1;
        ifid_d.instr = idata;
        ifid_d.pc    = pc_q;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iaddr       = pc_q;
  assign id_valid    = ifid_q.valid;
  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Three instances: default, no-fold, and wrap/saturate.
module tb_fetch_stage;

  localparam logic [15:0] W_ADDI  = 16'h804A;
  localparam logic [15:0] W_LD    = 16'h5011;
  localparam logic [15:0] W_ANDI  = 16'h9003;
  localparam logic [15:0] W_FFWD  = 16'h70B8;
  localparam logic [15:0] W_FBWD  = 16'h7E38;
  localparam logic [15:0] W_CCBZ  = 16'h7088;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // main instance
  logic        rst_n;
  logic [15:0] iaddr, idata;
  logic        stall, redir_valid;
  logic [15:0] redir_target;
  logic        id_valid;
  logic [15:0] id_instr, id_pc;
  logic [15:0] fetch_count;

  fetch_stage u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iaddr        (iaddr),
    .idata        (idata),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .fetch_count  (fetch_count)
  );

  // no-fold instance
  logic        nf_rst_n;
  logic [15:0] nf_iaddr, nf_idata;
  logic        nf_redir;
  logic [15:0] nf_tgt;
  logic        nf_valid;
  logic [15:0] nf_instr, nf_pc;
  logic [15:0] nf_cnt;

  fetch_stage #(
    .FOLD_UNCOND (0)
  ) u_nf (
    .clk          (clk),
    .rst_n        (nf_rst_n),
    .iaddr        (nf_iaddr),
    .idata        (nf_idata),
    .stall        (1'b0),
    .redir_valid  (nf_redir),
    .redir_target (nf_tgt),
    .id_valid     (nf_valid),
    .id_instr     (nf_instr),
    .id_pc        (nf_pc),
    .fetch_count  (nf_cnt)
  );

  // wrap + saturate instance
  logic        w_rst_n;
  logic [15:0] w_iaddr;
  logic        w_valid;
  logic [15:0] w_instr, w_pc;
  logic [3:0]  w_cnt;

  fetch_stage #(
    .RESET_PC (16'hFFFE),
    .CNT_W    (4)
  ) u_w (
    .clk          (clk),
    .rst_n        (w_rst_n),
    .iaddr        (w_iaddr),
    .idata        (W_ADDI),
    .stall        (1'b0),
    .redir_valid  (1'b0),
    .redir_target (16'h0000),
    .id_valid     (w_valid),
    .id_instr     (w_instr),
    .id_pc        (w_pc),
    .fetch_count  (w_cnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    nf_rst_n     = 1'b0;
    w_rst_n      = 1'b0;
    idata        = 16'h0000;
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = 16'h0000;
    nf_idata     = 16'h0000;
    nf_redir     = 1'b0;
    nf_tgt       = 16'h0000;

    repeat (2) tick();
    chk("rst_iaddr", iaddr, 16'h0000);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_idpc", id_pc, 16'h0000);
    chk("rst_cnt", fetch_count, 16'h0000);

    #3 rst_n = 1'b1;
    chk("boot_iaddr", iaddr, 16'h0000);
    idata = W_ADDI;
    tick();
    chk("post_boot_iaddr", iaddr, 16'h0000);
    chk("post_boot_valid", id_valid, 1'b0);
    chk("post_boot_cnt", fetch_count, 16'd0);

    // straight-line code
    tick();
    chk("s0_valid", id_valid, 1'b1);
    chk("s0_instr", id_instr, W_ADDI);
    chk("s0_idpc", id_pc, 16'h0000);
    chk("s0_iaddr", iaddr, 16'h0002);
    chk("s0_cnt", fetch_count, 16'd1);
    idata = W_LD;
    tick();
    chk("s1_instr", id_instr, W_LD);
    chk("s1_idpc", id_pc, 16'h0002);
    chk("s1_iaddr", iaddr, 16'h0004);
    idata = W_ANDI;
    tick();
    chk("s2_instr", id_instr, W_ANDI);
    chk("s2_idpc", id_pc, 16'h0004);
    idata = W_ADDI;
    tick();
    chk("s3_iaddr", iaddr, 16'h0008);
    chk("s3_cnt", fetch_count, 16'd4);

    // stall three cycles at 0x0008
    idata = W_LD;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_iaddr", iaddr, 16'h0008);
      chk("stall_idpc", id_pc, 16'h0006);
      chk("stall_valid", id_valid, 1'b1);
    end
    chk("stall_cnt", fetch_count, 16'd4);

    // redirect wins over stall, lsb dropped
    redir_valid  = 1'b1;
    redir_target = 16'h000D;
    tick();
    chk("redir_iaddr", iaddr, 16'h000C);
    chk("redir_valid", id_valid, 1'b0);
    chk("redir_cnt", fetch_count, 16'd4);

    // go to 0x000A for the forward fold
    stall        = 1'b0;
    redir_target = 16'h000A;
    tick();
    chk("redir2_iaddr", iaddr, 16'h000A);
    redir_valid = 1'b0;
    idata       = W_FFWD;
    tick();
    chk("ffwd_iaddr", iaddr, 16'h000E);
    chk("ffwd_valid", id_valid, 1'b0);
    chk("ffwd_cnt", fetch_count, 16'd4);

    idata = W_ADDI;
    tick();
    chk("e_idpc", id_pc, 16'h000E);
    chk("e_iaddr", iaddr, 16'h0010);
    chk("e_cnt", fetch_count, 16'd5);

    idata = W_FBWD;
    tick();
    chk("fbwd_iaddr", iaddr, 16'h0000);
    chk("fbwd_valid", id_valid, 1'b0);

    // conditional CBZ is forwarded
    idata = W_CCBZ;
    tick();
    chk("ccbz_valid", id_valid, 1'b1);
    chk("ccbz_instr", id_instr, W_CCBZ);
    chk("ccbz_iaddr", iaddr, 16'h0002);
    chk("ccbz_cnt", fetch_count, 16'd6);

    // async reset during a stall
    stall = 1'b1;
    idata = W_LD;
    tick();
    chk("pre_ar_iaddr", iaddr, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_iaddr", iaddr, 16'h0000);
    chk("ar_valid", id_valid, 1'b0);
    chk("ar_cnt", fetch_count, 16'd0);
    chk("ar_instr", id_instr, 16'h0000);
    stall = 1'b0;
    idata = W_ADDI;
    #2 rst_n = 1'b1;
    tick();
    chk("ar_boot_iaddr", iaddr, 16'h0000);
    chk("ar_boot_valid", id_valid, 1'b0);
    tick();
    chk("ar_run_valid", id_valid, 1'b1);
    chk("ar_run_idpc", id_pc, 16'h0000);
    chk("ar_run_iaddr", iaddr, 16'h0002);
    chk("ar_run_cnt", fetch_count, 16'd1);

    // FOLD_UNCOND = 0 forwards CBZ XZR
    #3 nf_rst_n = 1'b1;
    nf_redir = 1'b1;
    nf_tgt   = 16'h0010;
    tick();
    chk("nf_boot_iaddr", nf_iaddr, 16'h0000);
    tick();
    chk("nf_redir_iaddr", nf_iaddr, 16'h0010);
    nf_redir = 1'b0;
    nf_idata = W_FBWD;
    tick();
    chk("nf_iaddr", nf_iaddr, 16'h0012);
    chk("nf_valid", nf_valid, 1'b1);
    chk("nf_instr", nf_instr, W_FBWD);
    chk("nf_idpc", nf_pc, 16'h0010);
    chk("nf_cnt", nf_cnt, 16'd1);

    // PC wrap and 4-bit counter saturation
    #3 w_rst_n = 1'b1;
    chk("w_boot_iaddr", w_iaddr, 16'hFFFE);
    tick();
    chk("w_run_iaddr", w_iaddr, 16'hFFFE);
    tick();
    chk("w_wrap_iaddr", w_iaddr, 16'h0000);
    chk("w_wrap_idpc", w_pc, 16'hFFFE);
    chk("w_cnt1", w_cnt, 4'd1);
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (i == 14) chk("w_cnt14", w_cnt, 4'd14);
      if (i == 15) chk("w_cnt15", w_cnt, 4'hF);
    end
    chk("w_cnt20", w_cnt, 4'hF);
    chk("w_iaddr20", w_iaddr, 16'h0026);
    chk("w_valid20", w_valid, 1'b1);
    chk("w_instr20", w_instr, W_ADDI);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
